phase_drive_gen: RTL and testbench
==================================

// Module: phase_drive_gen
// PURPOSE
//  Generates the CDU four-phase timing drives from a single master clock.
//  Output is FAZ1DR..FAZ4DR plus FAZ2DR_n, all inactive-high drive levels.
//  Also stretches the moding zero command into ISSZDR.
//  Sits directly upstream of the phase/moding buffer stage, which inverts these drives into FAZnHI, ACDUZ, BCDUZ and CCDUZ.
// PARAMETERS
//  DIV      4  clk cycles per phase; legal range 2..64
//  PULSE_W  3  cycles FAZnDR is driven low at the start of its phase; legal range 1..DIV-1, which guarantees >=1 cycle of dead time
//  ZERO_CYC 2  minimum number of full 4-phase cycles that ISSZDR is held low per zero command; legal range 1..255
// PORTS
//  clk        in   1  master clock
//  rst        in   1  asynchronous, active-high reset
//  run_en     in   1  level; requests phase generation
//  zero_req   in   1  level; zero command from the moding logic (synchronous to clk)
//  FAZ1DR     out  1  phase-1 drive, active-low
//  FAZ2DR     out  1  phase-2 drive, active-low
//  FAZ2DR_n   out  1  exact complement of FAZ2DR
//  FAZ3DR     out  1  phase-3 drive, active-low
//  FAZ4DR     out  1  phase-4 drive, active-low
//  ISSZDR     out  1  zero drive, active-low
//  cyc_start  out  1  one-clk pulse on the first clk of every phase 1
//  running    out  1  high while state != IDLE
//  fault      out  1  sticky phase-monitor flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset values:
//   - FAZ1..4DR=1, FAZ2DR_n=0, ISSZDR=1, cyc_start=0, running=0, fault=0.
//   - State=IDLE; div_cnt=0; ph=0; zero_cnt=0.
//  Reset is asynchronous and takes effect immediately, mid-phase or mid-zero included.
//  Counters:
//   - div_cnt counts 0..DIV-1 and wraps.
//   - ph counts 0..3 (phase 1..4) and advances when div_cnt==DIV-1.
//   - ph wraps 3->0 at the cycle boundary.
//  All outputs are registered.
//   - FAZ(ph+1)DR = 0 iff state!=IDLE and div_cnt<PULSE_W; otherwise 1.
//   - At most one FAZnDR is low at any time, ever.
//  FSM:
//   - IDLE -> RUN when run_en=1. The first clk of RUN is ph=0, div_cnt=0, cyc_start=1.
//   - RUN -> DRAIN when run_en=0.
//   - DRAIN -> RUN when run_en returns to 1 before the end of phase 4; no gap, the count continues.
//   - DRAIN -> IDLE on the last clk of phase 4 (ph=3, div_cnt=DIV-1), so a drain always completes the current cycle.
//   - run_en=1 on that same last clk keeps the FSM in RUN.
//  Zero stretch:
//   - zero_req is sampled only at cycle boundaries, i.e. clks where cyc_start=1.
//   - If zero_req=1 and zero_cnt==0: load zero_cnt=ZERO_CYC and drive ISSZDR=0 from that same boundary.
//   - zero_cnt decrements at each later boundary.
//   - ISSZDR returns to 1 at the boundary where zero_cnt reaches 0, unless zero_req=1 there; in that case it reloads and stays low with no glitch.
//   - zero_req toggling between boundaries has no effect.
//   - On entry to IDLE: zero_cnt=0 and ISSZDR=1.
// CONFIGURATION
//  PHASE_MON_EN defined:
//   - Adds a registered checker.
//   - Sets fault=1 and holds it until rst if any of these occurs: more than one FAZnDR is low; FAZ2DR_n==FAZ2DR; a phase is skipped (next low drive is not (n mod 4)+1); or, in RUN, no drive goes low within 4*DIV clks.
//  PHASE_MON_EN undefined: fault is tied to 0 and no checker logic is built.
// STRUCTURE
//  Package cdu_timing_pkg:
//   - state_t enum {IDLE, RUN, DRAIN}
//   - phase_t 2-bit enum {PH1..PH4}
//   - function clog2_div
//   - elaboration assertions for the parameter ranges
//  Sub-module zero_stretch:
//   - inputs: boundary strobe, zero_req, clear
//   - outputs: ISSZDR, zero_cnt
//   - parameter: ZERO_CYC
// TESTING
//  1. DIV=4, PULSE_W=3, run_en=1 from reset -> FAZ1DR low at clks 0-2, FAZ2DR low 4-6, FAZ3DR low 8-10, FAZ4DR low 12-14; cyc_start at clks 0 and 16.
//  2. Drop run_en at clk 5 -> drives continue through clk 15; running=0 from clk 16; all DR=1.
//  3. Drop run_en at clk 5, raise it at clk 9 -> no gap, phase sequence uninterrupted; raise it at clk 15 -> stays RUN.
//  4. ZERO_CYC=2, 1-clk zero_req pulse at clk 17 -> no effect; zero_req held over clk 32 and dropped at clk 33 -> ISSZDR=0 for clks 32..63, 1 at clk 64.
//  5. Assert rst at clk 6 (FAZ2DR low) -> same clk: all DR=1, FAZ2DR_n=0, ISSZDR=1; restart begins at phase 1.
//  6. PHASE_MON_EN defined, force a double-low drive -> fault=1 next clk and held until rst; with the macro undefined, fault stays 0.

Source files
------------

// File: rtl/cdu_timing_pkg.sv
// Shared types and helpers for the CDU four-phase timing drive generator.
package cdu_timing_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef enum logic [1:0] {PH1, PH2, PH3, PH4} phase_t;

    localparam int unsigned ZeroCntW = 8;

    function automatic int unsigned clog2_div(input int unsigned div);
        return (div < 2) ? 1 : $clog2(div);
    endfunction

    // Legal ranges: DIV 2..64, PULSE_W 1..DIV-1, ZERO_CYC 1..255.
    function automatic bit params_ok(input int unsigned div, input int unsigned pulse_w,
                                     input int unsigned zero_cyc);
        return (div >= 2) && (div <= 64) && (pulse_w >= 1) && (pulse_w <= div - 1) &&
               (zero_cyc >= 1) && (zero_cyc <= 255);
    endfunction

endpackage

// File: rtl/zero_stretch.sv
// Stretches the moding zero command into ISSZDR, held low for ZERO_CYC whole cycles.
module zero_stretch
    import cdu_timing_pkg::*;
#(
    parameter int unsigned ZERO_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                strobe,
    input  logic                zero_req,
    input  logic                clear,
    output logic                ISSZDR,
    output logic [ZeroCntW-1:0] zero_cnt
);

    localparam logic [ZeroCntW-1:0] Load = ZeroCntW'(ZERO_CYC);

    logic [ZeroCntW-1:0] cnt_d, cnt_dec;
    logic                issz_d;

    always_comb begin
        cnt_d   = zero_cnt;
        issz_d  = ISSZDR;
        cnt_dec = (zero_cnt == '0) ? '0 : zero_cnt - 1'b1;
        if (clear) begin
            cnt_d  = '0;
            issz_d = 1'b1;
        end else if (strobe) begin
            // Expiry and a fresh request on the same boundary reload without releasing.
            if (cnt_dec == '0) begin
                cnt_d  = zero_req ? Load : '0;
                issz_d = ~zero_req;
            end else begin
                cnt_d  = cnt_dec;
                issz_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero_cnt <= '0;
            ISSZDR   <= 1'b1;
        end else begin
            zero_cnt <= cnt_d;
            ISSZDR   <= issz_d;
        end
    end

endmodule

// File: rtl/phase_drive_gen.sv
// CDU four-phase drive generator (FAZ1DR..FAZ4DR, ISSZDR) from one master clock.
// Optional phase monitor built when PHASE_MON_EN is defined; otherwise fault is tied low.
module phase_drive_gen
    import cdu_timing_pkg::*;
#(
    parameter int unsigned DIV      = 4,
    parameter int unsigned PULSE_W  = 3,
    parameter int unsigned ZERO_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run_en,
    input  logic zero_req,
    output logic FAZ1DR,
    output logic FAZ2DR,
    output logic FAZ2DR_n,
    output logic FAZ3DR,
    output logic FAZ4DR,
    output logic ISSZDR,
    output logic cyc_start,
    output logic running,
    output logic fault
);

    localparam int unsigned   DW     = clog2_div(DIV);
    localparam logic [DW-1:0] DivMax = DW'(DIV - 1);
    localparam logic [DW-1:0] PulseW = DW'(PULSE_W);

    if (!params_ok(DIV, PULSE_W, ZERO_CYC)) begin : g_bad_params
        $error("phase_drive_gen: DIV/PULSE_W/ZERO_CYC out of legal range");
    end

    state_t        state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    phase_t        ph_q, ph_d;
    logic [3:0]    faz_q, faz_d;
    logic          faz2n_q, cyc_q, cyc_d, run_q, last_clk;
    logic [ZeroCntW-1:0] zero_cnt_unused;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            ph_q    <= PH1;
            faz_q   <= 4'b1111;
            faz2n_q <= 1'b0;
            cyc_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            ph_q    <= ph_d;
            faz_q   <= faz_d;
            faz2n_q <= ~faz_d[1];
            cyc_q   <= cyc_d;
            run_q   <= (state_d != IDLE);
        end
    end

    always_comb begin
        last_clk = (ph_q == PH4) && (div_q == DivMax);
        state_d  = state_q;
        div_d    = '0;
        ph_d     = PH1;
        unique case (state_q)
            IDLE:    if (run_en) state_d = RUN;
            RUN:     if (!run_en) state_d = DRAIN;
            DRAIN: begin
                if (run_en)        state_d = RUN;
                else if (last_clk) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Counting carries on through DRAIN; the wrap on last_clk lands on the IDLE values.
        if (state_q != IDLE) begin
            div_d = (div_q == DivMax) ? '0 : div_q + 1'b1;
            ph_d  = (div_q == DivMax) ? phase_t'(ph_q + 2'd1) : ph_q;
        end
    end

    // Outputs are decoded from next state so the registered drives line up with the counters.
    always_comb begin
        faz_d = 4'b1111;
        if ((state_d != IDLE) && (div_d < PulseW)) faz_d[ph_d] = 1'b0;
        cyc_d = (state_d != IDLE) && (div_d == '0) && (ph_d == PH1);
    end

    assign FAZ1DR    = faz_q[0];
    assign FAZ2DR    = faz_q[1];
    assign FAZ3DR    = faz_q[2];
    assign FAZ4DR    = faz_q[3];
    assign FAZ2DR_n  = faz2n_q;
    assign cyc_start = cyc_q;
    assign running   = run_q;

    zero_stretch #(
        .ZERO_CYC(ZERO_CYC)
    ) u_zero_stretch (
        .clk     (clk),
        .rst     (rst),
        .strobe  (cyc_d),
        .zero_req(zero_req),
        .clear   (state_d == IDLE),
        .ISSZDR  (ISSZDR),
        .zero_cnt(zero_cnt_unused)
    );

`ifdef PHASE_MON_EN
    localparam int unsigned   TW      = $clog2(4 * DIV + 1);
    localparam logic [TW-1:0] QuietMx = TW'(4 * DIV);

    logic [3:0]    low_vec, low_prev_q;
    phase_t        last_q, ph_exp;
    logic [TW-1:0] quiet_q;
    logic          fault_q, err, new_low;

    assign low_vec = ~{FAZ4DR, FAZ3DR, FAZ2DR, FAZ1DR};

    always_comb begin
        ph_exp  = phase_t'(last_q + 2'd1);
        new_low = (low_vec != 4'd0) && (low_prev_q == 4'd0);
        err     = 1'b0;
        if ((low_vec & (low_vec - 4'd1)) != 4'd0)          err = 1'b1;
        if (FAZ2DR_n == FAZ2DR)                            err = 1'b1;
        if (new_low && (low_vec != (4'b0001 << ph_exp)))   err = 1'b1;
        if ((state_q == RUN) && (quiet_q == QuietMx))      err = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q    <= 1'b0;
            low_prev_q <= 4'd0;
            last_q     <= PH4;
            quiet_q    <= '0;
        end else begin
            fault_q    <= fault_q | err;
            low_prev_q <= low_vec;
            if (state_q == IDLE) last_q <= PH4;
            else if (new_low)    last_q <= ph_exp;
            if ((state_q != RUN) || (low_vec != 4'd0)) quiet_q <= '0;
            else if (quiet_q != QuietMx)               quiet_q <= quiet_q + 1'b1;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_phase_drive_gen.sv
// Directed self-checking bench for phase_drive_gen (DIV=4, PULSE_W=3, ZERO_CYC=2).
module tb_phase_drive_gen;

    logic clk = 1'b0;
    logic rst, run_en, zero_req;
    logic FAZ1DR, FAZ2DR, FAZ2DR_n, FAZ3DR, FAZ4DR, ISSZDR, cyc_start, running, fault;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    phase_drive_gen #(
        .DIV     (4),
        .PULSE_W (3),
        .ZERO_CYC(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .run_en   (run_en),
        .zero_req (zero_req),
        .FAZ1DR   (FAZ1DR),
        .FAZ2DR   (FAZ2DR),
        .FAZ2DR_n (FAZ2DR_n),
        .FAZ3DR   (FAZ3DR),
        .FAZ4DR   (FAZ4DR),
        .ISSZDR   (ISSZDR),
        .cyc_start(cyc_start),
        .running  (running),
        .fault    (fault)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // rel = clk offset from the first clk of a run; act = drives expected active
    task automatic chk_clk(input string tag, input int rel, input bit act);
        logic [3:0] e_faz;
        logic       e_f2n, e_cyc, e_run;
        e_faz = 4'b1111;
        if (act && ((rel % 4) < 3)) e_faz[(rel / 4) % 4] = 1'b0;
        e_f2n = ~e_faz[1];
        e_cyc = act && ((rel % 16) == 0);
        e_run = act;
        chk({tag, "/faz"},   {FAZ4DR, FAZ3DR, FAZ2DR, FAZ1DR}, e_faz);
        chk({tag, "/faz2n"}, {3'd0, FAZ2DR_n},  {3'd0, e_f2n});
        chk({tag, "/cyc"},   {3'd0, cyc_start}, {3'd0, e_cyc});
        chk({tag, "/run"},   {3'd0, running},   {3'd0, e_run});
        chk({tag, "/fault"}, {3'd0, fault},     4'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e_issz;
        rst      = 1'b1;
        run_en   = 1'b0;
        zero_req = 1'b0;
        step();
        step();
        chk_clk("reset", 0, 1'b0);
        chk("reset/issz", {3'd0, ISSZDR}, 4'd1);
        rst = 1'b0;
        step();
        chk_clk("idle", 0, 1'b0);

        // Continuous run: first cycle, then drop run_en at clk 5 of the second cycle.
        run_en = 1'b1;
        step();
        for (int k = 0; k < 16; k++) begin
            chk_clk("t1", k, 1'b1);
            step();
        end
        for (int k = 0; k < 18; k++) begin
            chk_clk("t2", k, k < 16);
            if (k == 5) run_en = 1'b0;
            step();
        end

        // Drain re-entry mid-cycle and on the last clk of phase 4.
        run_en = 1'b1;
        step();
        for (int k = 0; k <= 32; k++) begin
            chk_clk("t3", k, k < 32);
            if (k == 5)  run_en = 1'b0;
            if (k == 9)  run_en = 1'b1;
            if (k == 10) run_en = 1'b0;
            if (k == 15) run_en = 1'b1;
            if (k == 19) run_en = 1'b0;
            step();
        end

        // Zero stretch: ignored mid-cycle pulse, held request, then a second load before reset.
        run_en = 1'b1;
        step();
        for (int k = 0; k < 86; k++) begin
            e_issz = ((k >= 32) && (k < 64)) || (k >= 80) ? 1'b0 : 1'b1;
            chk_clk("t4", k, 1'b1);
            chk("t4/issz", {3'd0, ISSZDR}, {3'd0, e_issz});
            if (k == 17) zero_req = 1'b1;
            if (k == 18) zero_req = 1'b0;
            if (k == 30) zero_req = 1'b1;
            if (k == 33) zero_req = 1'b0;
            if (k == 79) zero_req = 1'b1;
            if (k == 80) zero_req = 1'b0;
            step();
        end

        // Asynchronous reset while FAZ2DR and ISSZDR are both low.
        chk_clk("t5pre", 86, 1'b1);
        chk("t5pre/issz", {3'd0, ISSZDR}, 4'd0);
        rst = 1'b1;
        #1;
        chk("t5/faz", {FAZ4DR, FAZ3DR, FAZ2DR, FAZ1DR}, 4'b1111);
        chk("t5/faz2n", {3'd0, FAZ2DR_n}, 4'd0);
        chk("t5/issz", {3'd0, ISSZDR}, 4'd1);
        chk("t5/run", {3'd0, running}, 4'd0);
        step();
        rst = 1'b0;
        step();
        for (int k = 0; k < 4; k++) begin
            chk_clk("t5restart", k, 1'b1);
            chk("t5restart/issz", {3'd0, ISSZDR}, 4'd1);
            step();
        end

`ifdef PHASE_MON_EN
        force dut.FAZ4DR = 1'b0;
        step();
        chk("t6/fault_set", {3'd0, fault}, 4'd1);
        release dut.FAZ4DR;
        step();
        step();
        chk("t6/fault_hold", {3'd0, fault}, 4'd1);
        rst = 1'b1;
        #1;
        chk("t6/fault_clr", {3'd0, fault}, 4'd0);
        step();
        rst = 1'b0;
`else
        chk("t6/fault_off", {3'd0, fault}, 4'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
